// File: rtl/vseven_seg_scanner_if.sv
// Display-side bundle of the seven-segment scanner: buffered digit data in, scan/drive outputs back.
// The scanner applies no backpressure; load is a fire-and-forget strobe.
interface vseven_seg_scanner_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output value, dp_in, blank_in, load,
        input  sel, an, seg, dp, frame_done
    );

    modport slave (
        input  value, dp_in, blank_in, load,
        output sel, an, seg, dp, frame_done
    );
endinterface

// File: rtl/vseven_seg_scanner.sv
// 4-digit seven-segment scanner, double-buffered at frame wrap; drives lag sel by 1 clock, load never stalled.
// Optional LEADING_ZERO_BLANK_EN: auto-darken leading zero digits 3..1.
module vseven_seg_scanner #(
    parameter int PRESCALE_W = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    vseven_seg_scanner_if.slave bus
);

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [1:0]            sel_q, sel_d;
    disp_t                 disp_q, disp_d;
    disp_t                 pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  started_q, started_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic       tick;
    logic       wrap;
    logic [3:0] nib;
    logic [3:0] auto_blank;
    logic       dark;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick         = &cnt_q;
        wrap         = tick && (sel_q == 2'd3);
        cnt_d        = cnt_q + PRESCALE_W'(1);
        sel_d        = tick ? sel_q + 2'd1 : sel_q;
        started_d    = started_q | tick;
        frame_done_d = wrap;

        // A load coinciding with the wrap still lets the older pending frame through first.
        disp_d     = (wrap && pend_vld_q) ? pend_q : disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (wrap) begin
            pend_vld_d = 1'b0;
        end
        if (bus.load) begin
            pend_d     = '{value: bus.value, dp: bus.dp_in, blank: bus.blank_in};
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        auto_blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        auto_blank[3] = (disp_q.value[15:12] == 4'h0);
        auto_blank[2] = (disp_q.value[15:8]  == 8'h00);
        auto_blank[1] = (disp_q.value[15:4]  == 12'h000);
`else
        auto_blank = 4'b0000;
`endif
        nib  = 4'(disp_q.value >> {sel_q, 2'b00});
        // Keep the display dark until the first scan step so reset shows nothing lit.
        dark = !started_q || disp_q.blank[sel_q] || auto_blank[sel_q];
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!dark) begin
            an_d  = ~(4'b0001 << sel_q);
            seg_d = decode(nib);
            dp_d  = ~disp_q.dp[sel_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sel_q        <= 2'd3;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            started_q    <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            started_q    <= started_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_vseven_seg_scanner.sv
// Directed plus random stimulus for the scanner, checked every clock against a frame-level display model.
module tb_vseven_seg_scanner;
    localparam int PW   = 2;
    localparam int DIG  = 1 << PW;
    localparam int FRM  = 4 * DIG;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vseven_seg_scanner_if bus();

    vseven_seg_scanner #(.PRESCALE_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: clocks since reset release, displayed and pending {value,dp,blank}.
    int          c;
    logic [23:0] m_disp;
    logic [23:0] m_pend;
    bit          m_pvld;

    logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sel_after(input int n);
        return (3 + n / DIG) % 4;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"}, 16'(bus.sel), 16'd3);
        chk({tag, "_an"},  16'(bus.an),  16'hF);
        chk({tag, "_seg"}, 16'(bus.seg), 16'h7F);
        chk({tag, "_dp"},  16'(bus.dp),  16'd1);
        chk({tag, "_fd"},  16'(bus.frame_done), 16'd0);
    endtask

    task automatic model_reset();
        c = 0; m_disp = '0; m_pend = '0; m_pvld = 0;
    endtask

    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        int          s;
        logic [15:0] dv;
        logic [3:0]  ean;
        logic [6:0]  eseg;
        logic        edp;
        bit          blank, wrap;
        bus.load = ld; bus.value = v; bus.dp_in = d; bus.blank_in = b;
        @(posedge clk);
        s     = sel_after(c);
        dv    = m_disp[23:8];
        blank = m_disp[s];
`ifdef LEADING_ZERO_BLANK_EN
        if (s != 0 && (dv >> (4 * s)) == 16'h0) blank = 1;
`endif
        ean = 4'hF; eseg = 7'h7F; edp = 1'b1;
        if (c >= DIG && !blank) begin
            ean  = 4'hF ^ (4'b0001 << s);
            eseg = dec_tbl[4'(dv >> (4 * s))];
            edp  = !m_disp[4 + s];
        end
        c++;
        wrap = (c % FRM) == DIG;
        if (wrap && m_pvld) begin
            m_disp = m_pend;
            m_pvld = 0;
        end
        if (ld) begin
            m_pend = {v, d, b};
            m_pvld = 1;
        end
        #1;
        chk("sel", 16'(bus.sel), 16'(sel_after(c)));
        chk("an",  16'(bus.an),  16'(ean));
        chk("seg", 16'(bus.seg), 16'(eseg));
        chk("dp",  16'(bus.dp),  16'(edp));
        chk("frame_done", 16'(bus.frame_done), 16'(wrap));
        bus.load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 4'h0, 4'h0);
    endtask

    initial begin
        bus.load = 0; bus.value = '0; bus.dp_in = '0; bus.blank_in = '0;
        model_reset();
        #12;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // First tick and first lit digit.
        idle(DIG - 1);
        chk("pre_tick_sel", 16'(bus.sel), 16'd3);
        idle(1);
        chk("first_tick_sel", 16'(bus.sel), 16'd0);
        chk("first_tick_fd", 16'(bus.frame_done), 16'd1);
        chk("first_tick_an", 16'(bus.an), 16'hF);
        idle(1);
        chk("first_lit_an", 16'(bus.an), 16'hE);
        chk("first_lit_seg", 16'(bus.seg), 16'h40);

        step(1, 16'h1A8F, 4'b0100, 4'b0000);
        idle(2 * FRM);

        // Load in mid-frame while digit 1 is selected.
        while (sel_after(c) != 1) idle(1);
        step(1, 16'h1234, 4'b0000, 4'b0000);
        idle(2 * FRM);

        // Pending 1111 plus a new 2222 landing on the wrap edge.
        while ((c % FRM) != DIG + 1) idle(1);
        step(1, 16'h1111, 4'b0000, 4'b0000);
        while (((c + 1) % FRM) != DIG) idle(1);
        step(1, 16'h2222, 4'b0000, 4'b0000);
        idle(2 * FRM + 2);

        step(1, 16'h8888, 4'b0000, 4'b1000);
        idle(2 * FRM);
        step(1, 16'h0050, 4'b0000, 4'b0000);
        idle(2 * FRM);

        for (int i = 0; i < 800; i++) begin
            logic [15:0] rv;
            rv = 16'($urandom) >> $urandom_range(0, 12);
            step(($urandom_range(0, 7) == 0), rv, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
        end

        // Asynchronous reset mid-frame with a load pending.
        idle(2);
        step(1, 16'hBEEF, 4'hF, 4'h0);
        idle(3);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        #1 rst_n = 1'b1;
        idle(3 * FRM);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
